reply_ctrl: RTL and testbench

Responder-side reply controller for the remote end of the command link. Each error-free received SR, DPR or CCW frame is answered with one reply word after a fixed response gap. A frame with errors gets no reply, and the error is flagged in the next status reply. This is what produces the initiator's no-reply and error conditions, so the initiator can run its repeat and source-switch logic. The block sits between the receiver deframer, the transmitter framer and the device application logic.

---
 rtl/reply_ctrl.sv | 142 ++++++++++++++
 tb/tb_reply_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reply_ctrl.sv
// rtl/reply_ctrl.sv - responder reply controller: answers good SR/DPR/CCW frames after a fixed gap
module reply_ctrl #(
  parameter int REPLY_GAP_TICKS  = 49,
  parameter int TX_TIMEOUT_TICKS = 4095
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        rx_start_bit_accepted,
  input  logic        rx_frame_end,
  input  logic        rx_err,
  input  logic [2:0]  rx_cmd_type,
  input  logic        dev_busy,
  input  logic [15:0] dpr_data,
  input  logic        tx_done,
  output logic        tx_start,
  output logic [15:0] tx_word,
  output logic        ccw_accepted,
  output logic        tx_fault
);

  localparam int GW = $clog2(REPLY_GAP_TICKS + 1);
  localparam int WW = $clog2(TX_TIMEOUT_TICKS + 1) + 1;

  typedef enum logic [1:0] {IDLE, GAP, SEND} state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] gap_q, gap_d, gap_inc;
  logic [WW-1:0] wd_q, wd_d;
  logic [2:0]    cmd_q, cmd_d;
  logic [15:0]   dpr_q, dpr_d;
  logic          busy_q, busy_d;
  logic          msg_err_q, msg_err_d;
  logic [7:0]    ccw_cnt_q, ccw_cnt_d;
  logic          tx_start_q, tx_start_d;
  logic [15:0]   tx_word_q, tx_word_d;
  logic          ccw_acc_q, ccw_acc_d;
  logic          tx_fault_q, tx_fault_d;
  logic          cmd_onehot, frame_bad, err_set, err_clr, busy_bit;

  assign cmd_onehot = (rx_cmd_type == 3'b001) || (rx_cmd_type == 3'b010) ||
                      (rx_cmd_type == 3'b100);
  assign frame_bad  = rx_frame_end & (rx_err | ~cmd_onehot);
  assign gap_inc    = gap_q + GW'(1);
  // CCW reports the busy state captured at frame end; SR reports it live at reply time
  assign busy_bit   = cmd_q[2] ? busy_q : dev_busy;

  always_comb begin
    state_d    = state_q;
    gap_d      = gap_q;
    wd_d       = wd_q;
    cmd_d      = cmd_q;
    dpr_d      = dpr_q;
    busy_d     = busy_q;
    ccw_cnt_d  = ccw_cnt_q;
    tx_word_d  = tx_word_q;
    tx_fault_d = tx_fault_q;
    tx_start_d = 1'b0;
    ccw_acc_d  = 1'b0;
    err_set    = 1'b0;
    err_clr    = 1'b0;
    case (state_q)
      IDLE: begin
        err_set = frame_bad;
        if (rx_frame_end && !rx_err && cmd_onehot) begin
          state_d = GAP;
          gap_d   = '0;
          cmd_d   = rx_cmd_type;
          dpr_d   = dpr_data;
          busy_d  = dev_busy;
        end
      end
      GAP: begin
        gap_d = gap_inc;
        if (rx_start_bit_accepted) begin
          state_d = IDLE;
          err_set = frame_bad;
        end else if (gap_inc == GW'(REPLY_GAP_TICKS)) begin
          state_d    = SEND;
          wd_d       = '0;
          tx_start_d = 1'b1;
          tx_word_d  = cmd_q[1] ? dpr_q
                     : {ccw_cnt_q, cmd_q, 2'b00, tx_fault_q, msg_err_q, busy_bit};
          if (cmd_q[2] && !busy_q) begin
            ccw_acc_d = 1'b1;
            ccw_cnt_d = ccw_cnt_q + 8'd1;
          end
        end
      end
      SEND: begin
        if (tx_done) begin
          state_d = IDLE;
          err_clr = cmd_q[0];
          err_set = frame_bad;
        end else if (wd_q == WW'(TX_TIMEOUT_TICKS)) begin
          state_d    = IDLE;
          tx_fault_d = 1'b1;
          err_set    = frame_bad;
        end else begin
          wd_d = wd_q + WW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    msg_err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : msg_err_q);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      gap_q      <= '0;
      wd_q       <= '0;
      cmd_q      <= '0;
      dpr_q      <= '0;
      busy_q     <= 1'b0;
      msg_err_q  <= 1'b0;
      ccw_cnt_q  <= '0;
      tx_start_q <= 1'b0;
      tx_word_q  <= '0;
      ccw_acc_q  <= 1'b0;
      tx_fault_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      wd_q       <= wd_d;
      cmd_q      <= cmd_d;
      dpr_q      <= dpr_d;
      busy_q     <= busy_d;
      msg_err_q  <= msg_err_d;
      ccw_cnt_q  <= ccw_cnt_d;
      tx_start_q <= tx_start_d;
      tx_word_q  <= tx_word_d;
      ccw_acc_q  <= ccw_acc_d;
      tx_fault_q <= tx_fault_d;
    end
  end

  assign tx_start     = tx_start_q;
  assign tx_word      = tx_word_q;
  assign ccw_accepted = ccw_acc_q;
  assign tx_fault     = tx_fault_q;

endmodule

// File: tb/tb_reply_ctrl.sv
// tb/tb_reply_ctrl.sv - self-checking bench for reply_ctrl
module tb_reply_ctrl;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        rx_start_bit_accepted;
  logic        rx_frame_end;
  logic        rx_err;
  logic [2:0]  rx_cmd_type;
  logic        dev_busy;
  logic [15:0] dpr_data;
  logic        tx_done;
  logic        tx_start;
  logic [15:0] tx_word;
  logic        ccw_accepted;
  logic        tx_fault;

  reply_ctrl dut (
    .clk                   (clk),
    .n_rst                 (n_rst),
    .rx_start_bit_accepted (rx_start_bit_accepted),
    .rx_frame_end          (rx_frame_end),
    .rx_err                (rx_err),
    .rx_cmd_type           (rx_cmd_type),
    .dev_busy              (dev_busy),
    .dpr_data              (dpr_data),
    .tx_done               (tx_done),
    .tx_start              (tx_start),
    .tx_word               (tx_word),
    .ccw_accepted          (ccw_accepted),
    .tx_fault              (tx_fault)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]  cmd;
    logic        err;
    logic        busy;
    logic [15:0] dpr;
    logic        reply;
    logic [15:0] word;
    logic        acc;
  } vec_t;

  typedef struct {
    logic [15:0] word;
    logic        acc;
    int          fe_cyc;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[16];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic drive_frame(input logic [2:0] cmd, input logic err, input logic [15:0] dpr,
                             output int fe);
    @(posedge clk); #1;
    rx_frame_end = 1'b1;
    rx_err       = err;
    rx_cmd_type  = cmd;
    dpr_data     = dpr;
    fe           = cyc;
    @(posedge clk); #1;
    rx_frame_end = 1'b0;
    rx_err       = 1'b0;
    rx_cmd_type  = 3'b000;
  endtask

  task automatic wait_tx(output logic seen);
    seen = 1'b0;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge clk);
      if (tx_start === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic pulse_done();
    @(posedge clk); #1 tx_done = 1'b1;
    @(posedge clk); #1 tx_done = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int   fe;
    logic seen;
    exp_t e;
    dev_busy = v.busy;
    drive_frame(v.cmd, v.err, v.dpr, fe);
    if (v.reply) sb.push_back('{v.word, v.acc, fe});
    wait_tx(seen);
    check({name, " tx_start"}, 32'(seen), 32'(v.reply));
    if (seen && sb.size() > 0) begin
      e = sb.pop_front();
      check({name, " tx_word"}, 32'(tx_word), 32'(e.word));
      check({name, " ccw_accepted"}, 32'(ccw_accepted), 32'(e.acc));
      check({name, " latency"}, 32'(cyc - e.fe_cyc), 32'd50);
    end
    if (seen) pulse_done();
    sb.delete();
    dev_busy = 1'b0;
  endtask

  function automatic vec_t mk(input logic [2:0] cmd, input logic err, input logic busy,
                              input logic [15:0] dpr, input logic reply,
                              input logic [15:0] word, input logic acc);
    vec_t v;
    v.cmd = cmd; v.err = err; v.busy = busy; v.dpr = dpr;
    v.reply = reply; v.word = word; v.acc = acc;
    return v;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: actual running required finished");
    $fatal(1, "timeout");
  end

  initial begin
    int   fe;
    int   t0;
    logic seen;

    n_rst = 1'b0;
    rx_start_bit_accepted = 1'b0;
    rx_frame_end = 1'b0;
    rx_err = 1'b0;
    rx_cmd_type = 3'b000;
    dev_busy = 1'b0;
    dpr_data = 16'h0;
    tx_done = 1'b0;

    tbl[0]  = mk(3'b001, 0, 0, 16'h0000, 1, 16'h0020, 0);
    tbl[1]  = mk(3'b100, 0, 0, 16'h0000, 1, 16'h0080, 1);
    tbl[2]  = mk(3'b100, 0, 1, 16'h0000, 1, 16'h0181, 0);
    tbl[3]  = mk(3'b001, 0, 1, 16'h0000, 1, 16'h0121, 0);
    tbl[4]  = mk(3'b010, 0, 0, 16'h1234, 1, 16'h1234, 0);
    tbl[5]  = mk(3'b001, 1, 0, 16'h0000, 0, 16'h0000, 0);
    tbl[6]  = mk(3'b001, 0, 0, 16'h0000, 1, 16'h0122, 0);
    tbl[7]  = mk(3'b001, 0, 0, 16'h0000, 1, 16'h0120, 0);
    tbl[8]  = mk(3'b011, 0, 0, 16'h0000, 0, 16'h0000, 0);
    tbl[9]  = mk(3'b010, 0, 0, 16'hBEEF, 1, 16'hBEEF, 0);
    tbl[10] = mk(3'b100, 0, 0, 16'h0000, 1, 16'h0182, 1);
    tbl[11] = mk(3'b001, 0, 0, 16'h0000, 1, 16'h0222, 0);
    tbl[12] = mk(3'b001, 0, 0, 16'h0000, 1, 16'h0220, 0);
    tbl[13] = mk(3'b000, 0, 0, 16'h0000, 0, 16'h0000, 0);
    tbl[14] = mk(3'b100, 1, 0, 16'h0000, 0, 16'h0000, 0);
    tbl[15] = mk(3'b001, 0, 0, 16'h0000, 1, 16'h0222, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset tx_start", 32'(tx_start), 32'd0);
    check("reset tx_word", 32'(tx_word), 32'd0);
    check("reset ccw_accepted", 32'(ccw_accepted), 32'd0);
    check("reset tx_fault", 32'(tx_fault), 32'd0);
    @(posedge clk); #1 n_rst = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 16; i++) run_vec(tbl[i], $sformatf("vec%0d", i));
    run_vec(mk(3'b001, 0, 0, 16'h0, 1, 16'h0220, 0), "after_table_sr");

    // reply aborted by a new start bit partway through the gap
    drive_frame(3'b010, 1'b0, 16'hA5C3, fe);
    repeat (19) @(posedge clk);
    #1 rx_start_bit_accepted = 1'b1;
    @(posedge clk); #1 rx_start_bit_accepted = 1'b0;
    wait_tx(seen);
    check("abort no tx_start", 32'(seen), 32'd0);
    run_vec(mk(3'b001, 0, 0, 16'h0, 1, 16'h0220, 0), "after_abort_sr");

    // frames arriving during SEND are ignored
    drive_frame(3'b001, 1'b0, 16'h0, fe);
    wait_tx(seen);
    check("send_ignore tx_start", 32'(seen), 32'd1);
    drive_frame(3'b001, 1'b1, 16'h0, fe);
    drive_frame(3'b010, 1'b0, 16'h1111, fe);
    pulse_done();
    wait_tx(seen);
    check("send_ignore no reply", 32'(seen), 32'd0);
    run_vec(mk(3'b001, 0, 0, 16'h0, 1, 16'h0220, 0), "send_ignore_sr");

    // error frame coinciding with an SR reply's tx_done: set beats clear
    drive_frame(3'b001, 1'b0, 16'h0, fe);
    wait_tx(seen);
    check("setwins tx_start", 32'(seen), 32'd1);
    @(posedge clk); #1;
    tx_done = 1'b1; rx_frame_end = 1'b1; rx_err = 1'b1; rx_cmd_type = 3'b001;
    @(posedge clk); #1;
    tx_done = 1'b0; rx_frame_end = 1'b0; rx_err = 1'b0; rx_cmd_type = 3'b000;
    run_vec(mk(3'b001, 0, 0, 16'h0, 1, 16'h0222, 0), "setwins_sr1");
    run_vec(mk(3'b001, 0, 0, 16'h0, 1, 16'h0220, 0), "setwins_sr2");

    // transmit watchdog
    drive_frame(3'b010, 1'b0, 16'h5A5A, fe);
    wait_tx(seen);
    check("timeout tx_start", 32'(seen), 32'd1);
    check("timeout tx_word", 32'(tx_word), 32'h5A5A);
    t0 = cyc;
    repeat (4095) @(negedge clk);
    check("timeout cycle", 32'(cyc - t0), 32'd4095);
    check("tx_fault before limit", 32'(tx_fault), 32'd0);
    @(negedge clk);
    check("tx_fault at limit", 32'(tx_fault), 32'd1);
    repeat (3) @(posedge clk);
    run_vec(mk(3'b001, 0, 0, 16'h0, 1, 16'h0224, 0), "after_fault_sr");

    // ccw_cnt wrap
    for (int n = 2; n < 256; n++)
      run_vec(mk(3'b100, 0, 0, 16'h0, 1, {8'(n), 8'h84}, 1), $sformatf("wrap%0d", n));
    run_vec(mk(3'b001, 0, 0, 16'h0, 1, 16'h0024, 0), "after_wrap_sr");

    // reset in SEND
    drive_frame(3'b100, 1'b0, 16'h0, fe);
    wait_tx(seen);
    check("rst_send tx_start", 32'(seen), 32'd1);
    n_rst = 1'b0;
    #1;
    check("rst_send tx_start low", 32'(tx_start), 32'd0);
    check("rst_send tx_word", 32'(tx_word), 32'd0);
    check("rst_send ccw_accepted", 32'(ccw_accepted), 32'd0);
    check("rst_send tx_fault", 32'(tx_fault), 32'd0);
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    wait_tx(seen);
    check("rst_send no tx_start", 32'(seen), 32'd0);
    run_vec(mk(3'b001, 0, 0, 16'h0, 1, 16'h0020, 0), "after_rst_sr");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
